digit_edit_scanner: RTL

- Upstream feeder of the 7-segment cursor-blink stage on the ARINC429 transmitter board.
- Debounces three user keys and maintains an editable 32-bit word as 8 hex digits, with cursor index cnt_out.
- Time-multiplexes the digits onto one segment bus, producing seg_in and disp_out for the blink stage.
- Presents the word to the ARINC429 transmitter; edits are frozen while a frame is transmitting.

---
 rtl/digit_edit_scanner.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/digit_edit_scanner.sv
`default_nettype none
//==============================================================================
// Module   : digit_edit_scanner
// Purpose  : Debounces three user keys (left / right / inc), maintains an
//            editable 32-bit word as 8 hex digits with a cursor, and
//            time-multiplexes the digits onto one 7-segment bus for the
//            cursor-blink stage. Edits are frozen while the ARINC429
//            transmitter is sending a frame.
// Ports    : clk, rst (async, active-high)
//            key_left, key_right, key_inc : raw active-low pushbuttons
//            txstate  : high while a frame is being transmitted
//            word     : edited word, nibble k = word[4k+3:4k]
//            seg_in   : active-low segment code {dp,g,f,e,d,c,b,a}
//            disp_out : digit currently scanned
//            cnt_out  : cursor digit index
//            dig_sel  : active-low one-hot digit enable for disp_out
// Revision : 1.0 - initial release
//==============================================================================
module digit_edit_scanner #(
   parameter int SCAN_DIV   = 50_000,
   parameter int DEB_CYCLES = 1_000_000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        key_left,
   input  logic        key_right,
   input  logic        key_inc,
   input  logic        txstate,
   output logic [31:0] word,
   output logic [7:0]  seg_in,
   output logic [2:0]  disp_out,
   output logic [2:0]  cnt_out,
   output logic [7:0]  dig_sel
);

   localparam int c_DEB_W  = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam int c_SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [c_DEB_W-1:0]  c_DEB_LAST  = c_DEB_W'(DEB_CYCLES - 1);
   localparam logic [c_SCAN_W-1:0] c_SCAN_LAST = c_SCAN_W'(SCAN_DIV - 1);

   // Key index: 0 = left, 1 = right, 2 = inc
   logic [2:0] w_key_raw;
   logic [2:0] r_sync1;
   logic [2:0] r_sync2;
   logic [2:0] r_deb;
   logic [2:0] r_press;

   assign w_key_raw = {key_inc, key_right, key_left};

   generate
      for (genvar k = 0; k < 3; k++) begin : g_key
         logic [c_DEB_W-1:0] r_cnt;

         // Counter runs only while the synchronised level differs from the
         // accepted level; any return to the accepted level restarts it, so
         // the new level must be seen for DEB_CYCLES consecutive cycles.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_sync1[k] <= 1'b1;
               r_sync2[k] <= 1'b1;
               r_deb[k]   <= 1'b1;
               r_press[k] <= 1'b0;
               r_cnt      <= '0;
            end else begin
               r_sync1[k] <= w_key_raw[k];
               r_sync2[k] <= r_sync1[k];
               r_press[k] <= 1'b0;
               if (r_sync2[k] == r_deb[k]) begin
                  r_cnt <= '0;
               end else if (r_cnt == c_DEB_LAST) begin
                  r_cnt    <= '0;
                  r_deb[k] <= r_sync2[k];
                  // Only the press (high-to-low) edge produces a pulse
                  r_press[k] <= ~r_sync2[k];
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
         end
      end
   endgenerate

   // Edit logic: inc has priority over left, left over right. Pulses seen
   // while transmitting are simply dropped.
   logic [31:0] r_word;
   logic [2:0]  r_cur;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_word <= '0;
         r_cur  <= '0;
      end else if (!txstate) begin
         if (r_press[2]) begin
            r_word[{r_cur, 2'b00} +: 4] <= r_word[{r_cur, 2'b00} +: 4] + 4'd1;
         end else if (r_press[0]) begin
            r_cur <= r_cur + 3'd1;
         end else if (r_press[1]) begin
            r_cur <= r_cur - 3'd1;
         end
      end
   end

   // Scanner
   logic [c_SCAN_W-1:0] r_pre;
   logic [2:0]          r_disp;
   logic [2:0]          w_disp_next;
   logic [3:0]          w_nib_next;
   logic [7:0]          w_seg_next;

   always_comb begin
      w_disp_next = r_disp;
      if (r_pre == c_SCAN_LAST) begin
         w_disp_next = r_disp + 3'd1;
      end
   end

   // Segment code is built from the digit that will be current after this
   // edge and the word as it stands now, so an edit shows up one cycle later.
   assign w_nib_next = r_word[{w_disp_next, 2'b00} +: 4];

   always_comb begin
      w_seg_next = 8'hC0;
      case (w_nib_next)
         4'h0: w_seg_next = 8'hC0;
         4'h1: w_seg_next = 8'hF9;
         4'h2: w_seg_next = 8'hA4;
         4'h3: w_seg_next = 8'hB0;
         4'h4: w_seg_next = 8'h99;
         4'h5: w_seg_next = 8'h92;
         4'h6: w_seg_next = 8'h82;
         4'h7: w_seg_next = 8'hF8;
         4'h8: w_seg_next = 8'h80;
         4'h9: w_seg_next = 8'h90;
         4'hA: w_seg_next = 8'h88;
         4'hB: w_seg_next = 8'h83;
         4'hC: w_seg_next = 8'hC6;
         4'hD: w_seg_next = 8'hA1;
         4'hE: w_seg_next = 8'h86;
         4'hF: w_seg_next = 8'h8E;
         default: w_seg_next = 8'hC0;
      endcase
   end

   logic [7:0] r_seg;
   logic [7:0] r_dig;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pre  <= '0;
         r_disp <= '0;
         r_seg  <= 8'hC0;
         r_dig  <= 8'hFE;
      end else begin
         if (r_pre == c_SCAN_LAST) begin
            r_pre <= '0;
         end else begin
            r_pre <= r_pre + 1'b1;
         end
         r_disp <= w_disp_next;
         r_seg  <= w_seg_next;
         r_dig  <= ~(8'b1 << w_disp_next);
      end
   end

   assign word     = r_word;
   assign cnt_out  = r_cur;
   assign disp_out = r_disp;
   assign seg_in   = r_seg;
   assign dig_sel  = r_dig;

endmodule
`default_nettype wire
